vx_fifo_queue_mq: RTL and testbench

- Multi-queue FIFO: NUM_QUEUES independent logical FIFOs of DEPTH entries each, sharing one dual-port RAM of NUM_QUEUES*DEPTH words.
- Used where per-warp, per-bank or per-channel ordering is required but separate FIFOs would waste RAM.
- Capabilities beyond the single-queue FIFO:
  - queue-select on push and pop;
  - non-power-of-2 DEPTH;
  - per-queue synchronous flush;
  - registered read response tagged with its queue id.

---
 rtl/vx_fifo_queue_mq.sv | 163 ++++++++++++++++
 tb/tb_vx_fifo_queue_mq.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/vx_fifo_queue_mq.sv
// vx_fifo_queue_mq: NUM_QUEUES independent FIFOs of DEPTH entries each, sharing
// one dual-port RAM of NUM_QUEUES*DEPTH words (queue q owns words
// q*DEPTH .. q*DEPTH+DEPTH-1).
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   push/push_qid     append data_in to the tail of queue push_qid
//   data_in           push payload
//   pop/pop_qid       remove the head of queue pop_qid
//   flush             per-queue flush mask (empties queue q on the next edge)
//   data_out          head entry for the previous cycle's pop
//   data_valid        data_out valid, one cycle after an accepted pop
//   data_qid          queue id of data_out
//   empty/alm_empty   per-queue size == 0 / size <= ALM_EMPTY (registered)
//   full/alm_full     per-queue size == DEPTH / size >= ALM_FULL (registered)
//   size              per-queue occupancy, queue q at [q*SIZEW +: SIZEW]
module vx_fifo_queue_mq #(
    parameter int DATAW      = 32,
    parameter int DEPTH      = 12,
    parameter int NUM_QUEUES = 4,
    parameter int ALM_FULL   = DEPTH - 1,
    parameter int ALM_EMPTY  = 1,
    parameter int LUTRAM     = 0,
    parameter int QIDW       = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1,
    parameter int SIZEW      = $clog2(DEPTH + 1)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        push,
    input  logic [QIDW-1:0]             push_qid,
    input  logic [DATAW-1:0]            data_in,
    input  logic                        pop,
    input  logic [QIDW-1:0]             pop_qid,
    input  logic [NUM_QUEUES-1:0]       flush,
    output logic [DATAW-1:0]            data_out,
    output logic                        data_valid,
    output logic [QIDW-1:0]             data_qid,
    output logic [NUM_QUEUES-1:0]       empty,
    output logic [NUM_QUEUES-1:0]       alm_empty,
    output logic [NUM_QUEUES-1:0]       full,
    output logic [NUM_QUEUES-1:0]       alm_full,
    output logic [NUM_QUEUES*SIZEW-1:0] size
);
    localparam int PTRW  = $clog2(DEPTH);
    localparam int WORDS = NUM_QUEUES * DEPTH;
    localparam int ADDRW = (WORDS > 1) ? $clog2(WORDS) : 1;

    if (DEPTH < 2) begin : g_bad_depth
        $error("vx_fifo_queue_mq: DEPTH must be >= 2");
    end
    if (ALM_FULL <= 0 || ALM_FULL >= DEPTH) begin : g_bad_alm_full
        $error("vx_fifo_queue_mq: ALM_FULL must satisfy 0 < ALM_FULL < DEPTH");
    end
    if (ALM_EMPTY <= 0 || ALM_EMPTY >= DEPTH) begin : g_bad_alm_empty
        $error("vx_fifo_queue_mq: ALM_EMPTY must satisfy 0 < ALM_EMPTY < DEPTH");
    end

    logic [QIDW-1:0]  wq, rq;
    logic [PTRW-1:0]  rd_ptr   [NUM_QUEUES];
    logic [PTRW-1:0]  wr_ptr   [NUM_QUEUES];
    logic [PTRW-1:0]  rd_ptr_n [NUM_QUEUES];
    logic [PTRW-1:0]  wr_ptr_n [NUM_QUEUES];
    logic [SIZEW-1:0] cnt      [NUM_QUEUES];
    logic [SIZEW-1:0] cnt_n    [NUM_QUEUES];
    logic             q_push   [NUM_QUEUES];
    logic             q_pop    [NUM_QUEUES];
    logic             wr_en, rd_en;
    logic [ADDRW-1:0] wr_addr, rd_addr;
    logic [DATAW-1:0] rd_data;

    // Queue ids carry no information with a single queue.
    assign wq = (NUM_QUEUES == 1) ? '0 : push_qid;
    assign rq = (NUM_QUEUES == 1) ? '0 : pop_qid;

    // Explicit wrap at DEPTH-1 so non-power-of-2 depths stay in their region.
    function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
        return (p == PTRW'(DEPTH - 1)) ? '0 : p + PTRW'(1);
    endfunction

    // Flush wins over a same-cycle push/pop on that queue.
    assign wr_en   = push && !flush[wq];
    assign rd_en   = pop && !flush[rq];
    assign wr_addr = ADDRW'(wq) * ADDRW'(DEPTH) + ADDRW'(wr_ptr[wq]);
    assign rd_addr = ADDRW'(rq) * ADDRW'(DEPTH) + ADDRW'(rd_ptr[rq]);

    always_comb begin
        for (int unsigned q = 0; q < NUM_QUEUES; q++) begin
            q_push[q]   = push && (wq == QIDW'(q)) && !flush[q];
            q_pop[q]    = pop && (rq == QIDW'(q)) && !flush[q];
            rd_ptr_n[q] = rd_ptr[q];
            wr_ptr_n[q] = wr_ptr[q];
            cnt_n[q]    = cnt[q];
            if (flush[q]) begin
                rd_ptr_n[q] = '0;
                wr_ptr_n[q] = '0;
                cnt_n[q]    = '0;
            end else begin
                if (q_push[q]) wr_ptr_n[q] = ptr_inc(wr_ptr[q]);
                if (q_pop[q])  rd_ptr_n[q] = ptr_inc(rd_ptr[q]);
                cnt_n[q] = cnt[q] + SIZEW'(q_push[q]) - SIZEW'(q_pop[q]);
            end
        end
    end

    // Read and write share one edge; the read sees the pre-write word, so a
    // pop+push on a full queue returns the old head while refilling its slot.
    if (LUTRAM != 0) begin : g_lutram
        (* ram_style = "distributed" *) logic [DATAW-1:0] ram [WORDS];
        always_ff @(posedge clk) begin
            if (wr_en) ram[wr_addr] <= data_in;
            if (rd_en) rd_data <= ram[rd_addr];
        end
    end else begin : g_bram
        (* ram_style = "block" *) logic [DATAW-1:0] ram [WORDS];
        always_ff @(posedge clk) begin
            if (wr_en) ram[wr_addr] <= data_in;
            if (rd_en) rd_data <= ram[rd_addr];
        end
    end

    assign data_out = rd_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned q = 0; q < NUM_QUEUES; q++) begin
                rd_ptr[q] <= '0;
                wr_ptr[q] <= '0;
                cnt[q]    <= '0;
            end
            empty      <= '1;
            alm_empty  <= '1;
            full       <= '0;
            alm_full   <= '0;
            data_valid <= 1'b0;
            data_qid   <= '0;
        end else begin
            for (int unsigned q = 0; q < NUM_QUEUES; q++) begin
                rd_ptr[q]    <= rd_ptr_n[q];
                wr_ptr[q]    <= wr_ptr_n[q];
                cnt[q]       <= cnt_n[q];
                empty[q]     <= (cnt_n[q] == '0);
                alm_empty[q] <= (cnt_n[q] <= SIZEW'(ALM_EMPTY));
                full[q]      <= (cnt_n[q] == SIZEW'(DEPTH));
                alm_full[q]  <= (cnt_n[q] >= SIZEW'(ALM_FULL));
            end
            data_valid <= rd_en;
            if (rd_en) data_qid <= rq;
        end
    end

    always_comb begin
        size = '0;
        for (int unsigned q = 0; q < NUM_QUEUES; q++) begin
            size[q*SIZEW +: SIZEW] = cnt[q];
        end
    end

    a_no_push_full: assert property (@(posedge clk) disable iff (reset)
        (push && !flush[wq] && full[wq]) |-> (pop && rq == wq));
    a_no_pop_empty: assert property (@(posedge clk) disable iff (reset)
        (pop && !flush[rq]) |-> !empty[rq]);

endmodule

// File: tb/tb_vx_fifo_queue_mq.sv
// Directed bench for vx_fifo_queue_mq (DATAW=32, DEPTH=12, NUM_QUEUES=4).
module tb_vx_fifo_queue_mq;
    logic        clk = 1'b0;
    logic        reset, push, pop;
    logic [1:0]  push_qid, pop_qid, data_qid;
    logic [31:0] data_in, data_out;
    logic [3:0]  flush, empty, alm_empty, full, alm_full;
    logic        data_valid;
    logic [15:0] size;

    int errors = 0;
    int checks = 0;

    vx_fifo_queue_mq #(
        .DATAW(32), .DEPTH(12), .NUM_QUEUES(4), .ALM_FULL(11), .ALM_EMPTY(1), .LUTRAM(0)
    ) dut (
        .clk(clk), .reset(reset), .push(push), .push_qid(push_qid), .data_in(data_in),
        .pop(pop), .pop_qid(pop_qid), .flush(flush), .data_out(data_out),
        .data_valid(data_valid), .data_qid(data_qid), .empty(empty),
        .alm_empty(alm_empty), .full(full), .alm_full(alm_full), .size(size)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        push;
        logic [1:0]  pq;
        logic [31:0] din;
        logic        pop;
        logic [1:0]  oq;
        logic        ev;
        logic [1:0]  eq;
        logic [31:0] ed;
        logic [15:0] esize;
        logic [3:0]  eempty;
    } vec_t;

    function automatic vec_t mk(input int pu, input int pq, input int din, input int po,
                                input int oq, input int ev, input int eq, input int ed,
                                input int esize, input int eempty);
        vec_t v;
        v.push = pu[0];   v.pq = pq[1:0]; v.din = din[31:0];
        v.pop  = po[0];   v.oq = oq[1:0];
        v.ev   = ev[0];   v.eq = eq[1:0]; v.ed = ed[31:0];
        v.esize = esize[15:0]; v.eempty = eempty[3:0];
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample #1 after the edge.
    task automatic step(input logic pu, input logic [1:0] pq, input logic [31:0] d,
                        input logic po, input logic [1:0] oq, input logic [3:0] fl,
                        input logic rs);
        push = pu; push_qid = pq; data_in = d;
        pop = po;  pop_qid = oq;  flush = fl; reset = rs;
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0; flush = '0; reset = 1'b0;
    endtask

    vec_t        vt [17];
    logic [31:0] model [$];
    logic [31:0] exp;

    initial begin
        push = 0; pop = 0; push_qid = 0; pop_qid = 0; data_in = 0; flush = 0; reset = 1;
        step(0, 0, 0, 0, 0, 4'h0, 1);
        step(0, 0, 0, 0, 0, 4'h0, 1);
        chk("rst_empty", 32'(empty), 32'hF);
        chk("rst_alm_empty", 32'(alm_empty), 32'hF);
        chk("rst_full", 32'(full), 32'h0);
        chk("rst_alm_full", 32'(alm_full), 32'h0);
        chk("rst_valid", 32'(data_valid), 32'h0);
        chk("rst_qid", 32'(data_qid), 32'h0);
        chk("rst_size", 32'(size), 32'h0);

        // push/pop on q2, then interleaved traffic on q0/q3/q1
        vt[0]  = mk(1, 2, 'hA0, 0, 0, 0, 0, 0,     'h0100, 'b1011);
        vt[1]  = mk(1, 2, 'hA1, 0, 0, 0, 0, 0,     'h0200, 'b1011);
        vt[2]  = mk(1, 2, 'hA2, 0, 0, 0, 0, 0,     'h0300, 'b1011);
        vt[3]  = mk(1, 2, 'hA3, 0, 0, 0, 0, 0,     'h0400, 'b1011);
        vt[4]  = mk(0, 0, 0,     1, 2, 1, 2, 'hA0, 'h0300, 'b1011);
        vt[5]  = mk(0, 0, 0,     1, 2, 1, 2, 'hA1, 'h0200, 'b1011);
        vt[6]  = mk(0, 0, 0,     1, 2, 1, 2, 'hA2, 'h0100, 'b1011);
        vt[7]  = mk(0, 0, 0,     1, 2, 1, 2, 'hA3, 'h0000, 'b1111);
        vt[8]  = mk(0, 0, 0,     0, 0, 0, 0, 0,     'h0000, 'b1111);
        vt[9]  = mk(1, 0, 'h10, 0, 0, 0, 0, 0,     'h0001, 'b1110);
        vt[10] = mk(1, 3, 'h30, 0, 0, 0, 0, 0,     'h1001, 'b0110);
        vt[11] = mk(1, 0, 'h11, 0, 0, 0, 0, 0,     'h1002, 'b0110);
        vt[12] = mk(0, 0, 0,     1, 3, 1, 3, 'h30, 'h0002, 'b1110);
        vt[13] = mk(1, 1, 'h21, 1, 0, 1, 0, 'h10, 'h0011, 'b1100);
        vt[14] = mk(0, 0, 0,     1, 0, 1, 0, 'h11, 'h0010, 'b1101);
        vt[15] = mk(0, 0, 0,     1, 1, 1, 1, 'h21, 'h0000, 'b1111);
        vt[16] = mk(0, 0, 0,     0, 0, 0, 0, 0,     'h0000, 'b1111);

        for (int i = 0; i < 17; i++) begin
            step(vt[i].push, vt[i].pq, vt[i].din, vt[i].pop, vt[i].oq, 4'h0, 1'b0);
            chk($sformatf("vec%0d_valid", i), 32'(data_valid), 32'(vt[i].ev));
            if (vt[i].ev) begin
                chk($sformatf("vec%0d_qid", i), 32'(data_qid), 32'(vt[i].eq));
                chk($sformatf("vec%0d_data", i), data_out, vt[i].ed);
            end
            chk($sformatf("vec%0d_size", i), 32'(size), 32'(vt[i].esize));
            chk($sformatf("vec%0d_empty", i), 32'(empty), 32'(vt[i].eempty));
            chk($sformatf("vec%0d_full", i), 32'(full), 32'h0);
        end

        // q1: fill to DEPTH, partial drain, refill across the pointer wrap
        for (int i = 0; i < 12; i++) begin
            step(1, 1, 32'hB0 + 32'(i), 0, 0, 4'h0, 0);
            model.push_back(32'hB0 + 32'(i));
            if (i == 10) begin
                chk("q1_11_alm_full", 32'(alm_full[1]), 32'h1);
                chk("q1_11_full", 32'(full[1]), 32'h0);
            end
        end
        chk("q1_full", 32'(full[1]), 32'h1);
        chk("q1_size12", 32'(size[7:4]), 32'd12);
        chk("q1_alm_empty_full", 32'(alm_empty[1]), 32'h0);
        for (int i = 0; i < 5; i++) begin
            exp = model.pop_front();
            step(0, 0, 0, 1, 1, 4'h0, 0);
            chk("q1_pop5_valid", 32'(data_valid), 32'h1);
            chk("q1_pop5_data", data_out, exp);
        end
        chk("q1_size7", 32'(size[7:4]), 32'd7);
        for (int i = 0; i < 5; i++) begin
            step(1, 1, 32'hC0 + 32'(i), 0, 0, 4'h0, 0);
            model.push_back(32'hC0 + 32'(i));
        end
        chk("q1_refull", 32'(full[1]), 32'h1);

        // same-cycle push/pop on a full queue
        exp = model.pop_front();
        model.push_back(32'h55);
        step(1, 1, 32'h55, 1, 1, 4'h0, 0);
        chk("fullpp_valid", 32'(data_valid), 32'h1);
        chk("fullpp_data", data_out, exp);
        chk("fullpp_size", 32'(size[7:4]), 32'd12);
        chk("fullpp_full", 32'(full[1]), 32'h1);

        while (model.size() > 0) begin
            exp = model.pop_front();
            step(0, 0, 0, 1, 1, 4'h0, 0);
            chk("drain_valid", 32'(data_valid), 32'h1);
            chk("drain_qid", 32'(data_qid), 32'h1);
            chk("drain_data", data_out, exp);
            if (model.size() == 1) chk("drain_alm_empty1", 32'(alm_empty[1]), 32'h1);
            if (model.size() == 2) chk("drain_alm_empty2", 32'(alm_empty[1]), 32'h0);
        end
        chk("drain_last_55", data_out, 32'h55);
        chk("drain_empty", 32'(empty), 32'hF);

        // flush q0 with a same-cycle push; q1 must be untouched
        for (int i = 0; i < 3; i++) step(1, 0, 32'hD0 + 32'(i), 0, 0, 4'h0, 0);
        step(1, 1, 32'hE0, 0, 0, 4'h0, 0);
        step(1, 1, 32'hE1, 0, 0, 4'h0, 0);
        chk("preflush_size", 32'(size), 32'h0023);
        step(1, 0, 32'hDD, 0, 0, 4'h1, 0);
        chk("flush_size0", 32'(size[3:0]), 32'h0);
        chk("flush_empty0", 32'(empty[0]), 32'h1);
        chk("flush_size1", 32'(size[7:4]), 32'h2);
        step(1, 0, 32'h77, 0, 0, 4'h0, 0);
        step(0, 0, 0, 1, 0, 4'h0, 0);
        chk("postflush_valid", 32'(data_valid), 32'h1);
        chk("postflush_qid", 32'(data_qid), 32'h0);
        chk("postflush_data", data_out, 32'h77);
        step(0, 0, 0, 1, 1, 4'h0, 0);
        chk("q1_intact0", data_out, 32'hE0);
        step(0, 0, 0, 1, 1, 4'h0, 0);
        chk("q1_intact1", data_out, 32'hE1);

        // pop on a queue being flushed gives no response
        step(1, 2, 32'h42, 0, 0, 4'h0, 0);
        step(0, 0, 0, 1, 2, 4'h4, 0);
        chk("flushpop_valid", 32'(data_valid), 32'h0);
        chk("flushpop_empty", 32'(empty), 32'hF);

        // reset right after a pop
        step(1, 0, 32'h01, 0, 0, 4'h0, 0);
        step(1, 2, 32'h66, 0, 0, 4'h0, 0);
        step(0, 0, 0, 1, 2, 4'h0, 0);
        chk("prereset_data", data_out, 32'h66);
        step(0, 0, 0, 0, 0, 4'h0, 1);
        chk("postreset_valid", 32'(data_valid), 32'h0);
        chk("postreset_empty", 32'(empty), 32'hF);
        chk("postreset_size", 32'(size), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
